tap_gesture_ctrl: RTL and testbench

- Classifies a debounced push-button into single-tap, double-tap and long-press gestures using 1 kHz (1 ms) timing.
- Sequences a mode register from those gestures: single advances the LED mode, double steps back, long resets.
- Sits between the button debouncer and the LED pattern generators.
- Single owner of button gesture timing.

---
 rtl/tap_gesture_pkg.sv | 24 ++
 rtl/tap_gesture_ctrl_ms_timer.sv | 45 ++++
 rtl/tap_gesture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tap_gesture_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_gesture_pkg.sv
// Shared types and constants for the tap gesture controller.
//   - state_e : gesture FSM state encoding (IDLE=0 .. HOLD=4)
//   - evt_e   : event code produced by the FSM for one cycle
//   - TIMER_W : width of the millisecond timer
package tap_gesture_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SINGLE = 2'd1,
    EVT_DOUBLE = 2'd2,
    EVT_LONG   = 2'd3
  } evt_e;

endpackage

// File: rtl/tap_gesture_ctrl_ms_timer.sv
// Millisecond timer: 16-bit counter that saturates at all-ones, with a
// synchronous clear and a compare flag for (count == limit - 1).
// Ports:
//   clk_1k : 1 kHz clock          rstn  : async active-low reset
//   clr    : synchronous clear    limit : compare limit (flag at limit-1)
//   count  : current count        hit   : count == limit - 1
module ms_timer
  import tap_gesture_pkg::*;
(
  input  logic               clk_1k,
  input  logic               rstn,
  input  logic               clr,
  input  logic [TIMER_W-1:0] limit,
  output logic [TIMER_W-1:0] count,
  output logic               hit
);

  logic [TIMER_W-1:0] count_d;
  logic [TIMER_W-1:0] count_q;

  // Next count: clear wins, otherwise count up and hold at saturation.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {TIMER_W{1'b0}};
    end else if (count_q == {TIMER_W{1'b1}}) begin
      count_d = count_q;
    end else begin
      count_d = count_q + {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hit   = (count_q == (limit - {{(TIMER_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/tap_gesture_ctrl.sv
// Tap gesture controller: classifies a debounced button into single-tap,
// double-tap and long-press gestures on a 1 kHz time base and steps an LED
// mode register from them (single: +1, double: -1, long: reset to 0).
// Optional build macro TAP_GESTURE_REPEAT_EN: while held past a long press,
// emit a single_evt every REPEAT_MS ms until release.
// Ports:
//   clk_1k     : 1 kHz clock            rstn       : async active-low reset
//   btn_in     : debounced button (async to clk_1k), active-high
//   enable     : gesture engine enable (0 forces FSM idle, mode holds)
//   mode       : current LED mode (0..N_MODES-1)
//   single_evt : 1-cycle pulse per single tap (or auto-repeat)
//   double_evt : 1-cycle pulse per double tap
//   long_evt   : 1-cycle pulse per long press
//   busy       : FSM not in IDLE
module tap_gesture_ctrl
  import tap_gesture_pkg::*;
#(
  parameter int N_MODES    = 4,
  parameter int MODE_W     = 4,
  parameter int DBL_WIN_MS = 300,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 250
) (
  input  logic              clk_1k,
  input  logic              rstn,
  input  logic              btn_in,
  input  logic              enable,
  output logic [MODE_W-1:0] mode,
  output logic              single_evt,
  output logic              double_evt,
  output logic              long_evt,
  output logic              busy
);

  // Reject configurations outside the supported ranges at elaboration.
  if (N_MODES < 2 || N_MODES > 16 || (2 ** MODE_W) < N_MODES ||
      DBL_WIN_MS < 1 || DBL_WIN_MS > 65535 || LONG_MS < 2 || LONG_MS > 65535 ||
      REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_check
    $error("tap_gesture_ctrl: parameter out of range");
  end

  localparam logic [TIMER_W-1:0] LONG_LIM = TIMER_W'(LONG_MS);
  localparam logic [TIMER_W-1:0] DBL_LIM  = TIMER_W'(DBL_WIN_MS);
  localparam logic [MODE_W-1:0]  MODE_MAX = MODE_W'(N_MODES - 1);
`ifdef TAP_GESTURE_REPEAT_EN
  localparam logic [TIMER_W-1:0] RPT_LIM  = TIMER_W'(REPEAT_MS);
`endif

  logic               sync1_q, btn_s_q, btn_d_q;
  logic               rise_s, fall_s;
  state_e             state_d, state_q;
  evt_e               evt_d;
  logic               single_evt_q, double_evt_q, long_evt_q;
  logic [MODE_W-1:0]  mode_d, mode_q;
  logic               rpt_clr_s, tmr_clr_s, tmr_hit_s;
  logic [TIMER_W-1:0] tmr_lim_s, tmr_cnt_s;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      btn_d_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      btn_s_q <= sync1_q;
      btn_d_q <= btn_s_q;
    end
  end

  assign rise_s = btn_s_q & ~btn_d_q;
  assign fall_s = ~btn_s_q & btn_d_q;

  // Select the timeout the timer compares against in the current state.
  always_comb begin
    case (state_q)
      PRESS1:  tmr_lim_s = LONG_LIM;
      WAIT2:   tmr_lim_s = DBL_LIM;
`ifdef TAP_GESTURE_REPEAT_EN
      HOLD:    tmr_lim_s = RPT_LIM;
`endif
      default: tmr_lim_s = LONG_LIM;
    endcase
  end

  ms_timer u_timer (
    .clk_1k (clk_1k),
    .rstn   (rstn),
    .clr    (tmr_clr_s),
    .limit  (tmr_lim_s),
    .count  (tmr_cnt_s),
    .hit    (tmr_hit_s)
  );

  // Gesture next-state and event decode; enable low parks the FSM in IDLE.
  always_comb begin
    state_d   = state_q;
    evt_d     = EVT_NONE;
    rpt_clr_s = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_s) state_d = PRESS1;
          else        state_d = IDLE;
        end
        PRESS1: begin
          if (fall_s) begin
            state_d = WAIT2;
          end else if (tmr_hit_s) begin
            state_d = HOLD;
            evt_d   = EVT_LONG;
          end else begin
            state_d = PRESS1;
          end
        end
        WAIT2: begin
          // A second rise on the last window cycle still counts as double.
          if (rise_s && (tmr_cnt_s <= (DBL_LIM - 16'd1))) begin
            state_d = PRESS2;
            evt_d   = EVT_DOUBLE;
          end else if (tmr_hit_s) begin
            state_d = IDLE;
            evt_d   = EVT_SINGLE;
          end else begin
            state_d = WAIT2;
          end
        end
        PRESS2: begin
          if (fall_s) state_d = IDLE;
          else        state_d = PRESS2;
        end
        HOLD: begin
          if (fall_s) begin
            state_d = IDLE;
`ifdef TAP_GESTURE_REPEAT_EN
          end else if (tmr_hit_s) begin
            state_d   = HOLD;
            evt_d     = EVT_SINGLE;
            rpt_clr_s = 1'b1;
`endif
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Timer restarts on every state change, every auto-repeat and while disabled.
  assign tmr_clr_s = (state_d != state_q) | rpt_clr_s | ~enable;

  // Mode update one cycle after the registered event pulse.
  always_comb begin
    mode_d = mode_q;
    if (single_evt_q) begin
      mode_d = (mode_q == MODE_MAX) ? {MODE_W{1'b0}} : mode_q + {{(MODE_W-1){1'b0}}, 1'b1};
    end else if (double_evt_q) begin
      mode_d = (mode_q == {MODE_W{1'b0}}) ? MODE_MAX : mode_q - {{(MODE_W-1){1'b0}}, 1'b1};
    end else if (long_evt_q) begin
      mode_d = {MODE_W{1'b0}};
    end else begin
      mode_d = mode_q;
    end
  end

  // FSM state, event pulses and mode register.
  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      single_evt_q <= 1'b0;
      double_evt_q <= 1'b0;
      long_evt_q   <= 1'b0;
      mode_q       <= {MODE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      single_evt_q <= (evt_d == EVT_SINGLE);
      double_evt_q <= (evt_d == EVT_DOUBLE);
      long_evt_q   <= (evt_d == EVT_LONG);
      mode_q       <= mode_d;
    end
  end

  assign mode       = mode_q;
  assign single_evt = single_evt_q;
  assign double_evt = double_evt_q;
  assign long_evt   = long_evt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tap_gesture_ctrl.sv
// Self-checking bench for tap_gesture_ctrl (default parameters).
// Expected gesture events (kind, cycle, resulting mode) are queued when the
// button stimulus is driven and popped when the DUT pulses an event.
module tb_tap_gesture_ctrl;

  localparam int N_MODES = 4;
  localparam int K_SINGLE = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG   = 3;

  logic       clk_1k = 1'b0;
  logic       rstn;
  logic       btn_in;
  logic       enable;
  logic [3:0] mode;
  logic       single_evt, double_evt, long_evt, busy;

  tap_gesture_ctrl dut (
    .clk_1k     (clk_1k),
    .rstn       (rstn),
    .btn_in     (btn_in),
    .enable     (enable),
    .mode       (mode),
    .single_evt (single_evt),
    .double_evt (double_evt),
    .long_evt   (long_evt),
    .busy       (busy)
  );

  always #5 clk_1k = ~clk_1k;

  int cyc = 0;
  always @(posedge clk_1k) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int kind;
    int at;
    int mode;
  } exp_t;

  exp_t sb[$];
  int   mdl_mode = 0;

  function automatic void expect_evt(input int kind, input int at);
    exp_t e;
    if (kind == K_SINGLE)      mdl_mode = (mdl_mode == N_MODES - 1) ? 0 : mdl_mode + 1;
    else if (kind == K_DOUBLE) mdl_mode = (mdl_mode == 0) ? N_MODES - 1 : mdl_mode - 1;
    else                       mdl_mode = 0;
    e.kind = kind;
    e.at   = at;
    e.mode = mdl_mode;
    sb.push_back(e);
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_1k);
  endtask

  // Event monitor: compares each pulse against the scoreboard head.
  initial begin
    int   nev, obs_kind, pend_mode;
    bit   pend_chk;
    exp_t e;
    pend_chk = 1'b0;
    pend_mode = 0;
    forever begin
      @(negedge clk_1k);
      if (pend_chk) begin
        check_eq("mode_upd", 32'(mode), 32'(pend_mode));
        pend_chk = 1'b0;
      end
      if (sb.size() > 0 && cyc > sb[0].at) begin
        check_eq("evt_missing", 32'd0, 32'(sb[0].kind));
        e = sb.pop_front();
      end
      nev = int'(single_evt) + int'(double_evt) + int'(long_evt);
      if (nev != 0) begin
        obs_kind = single_evt ? K_SINGLE : (double_evt ? K_DOUBLE : K_LONG);
        check_eq("one_evt", 32'(nev), 32'd1);
        if (sb.size() == 0) begin
          check_eq("unexpected_evt", 32'(obs_kind), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("evt_kind", 32'(obs_kind), 32'(e.kind));
          check_eq("evt_cycle", 32'(cyc), 32'(e.at));
          pend_mode = e.mode;
          pend_chk  = 1'b1;
        end
      end
    end
  end

  task automatic single_tap(input int hold);
    int b;
    btn_in = 1'b1;
    wait_n(hold);
    b = cyc;
    btn_in = 1'b0;
    expect_evt(K_SINGLE, b + 303);
    wait_n(302);
    check_eq("busy_wait2", 32'(busy), 32'd1);
    wait_n(8);
    check_eq("busy_after_single", 32'(busy), 32'd0);
  endtask

  initial begin
    int a, b, c, d;
    rstn   = 1'b0;
    btn_in = 1'b0;
    enable = 1'b1;
    wait_n(3);
    check_eq("rst_mode", 32'(mode), 32'd0);
    check_eq("rst_single", 32'(single_evt), 32'd0);
    check_eq("rst_double", 32'(double_evt), 32'd0);
    check_eq("rst_long", 32'(long_evt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    wait_n(5);

    // Double tap from mode 0: wraps down to N_MODES-1.
    btn_in = 1'b1;
    wait_n(80);
    btn_in = 1'b0;
    wait_n(150);
    c = cyc;
    btn_in = 1'b1;
    expect_evt(K_DOUBLE, c + 3);
    wait_n(80);
    btn_in = 1'b0;
    wait_n(5);
    check_eq("busy_after_double", 32'(busy), 32'd0);

    // Single taps: 3->0 (wrap up), 0->1, 1->2.
    single_tap(100);
    single_tap(100);
    single_tap(100);

    // Long press from mode 2.
    a = cyc;
    btn_in = 1'b1;
    expect_evt(K_LONG, a + 1003);
`ifdef TAP_GESTURE_REPEAT_EN
    expect_evt(K_SINGLE, a + 1253);
`endif
    wait_n(1500);
    btn_in = 1'b0;
    wait_n(2);
    check_eq("busy_hold_tail", 32'(busy), 32'd1);
    wait_n(1);
    check_eq("busy_after_long", 32'(busy), 32'd0);
    wait_n(5);

    // Second rise seen with timer=299: still a double tap.
    btn_in = 1'b1;
    wait_n(50);
    b = cyc;
    btn_in = 1'b0;
    wait_n(300);
    c = cyc;
    btn_in = 1'b1;
    expect_evt(K_DOUBLE, c + 3);
    wait_n(50);
    btn_in = 1'b0;
    wait_n(10);

    // Second rise one cycle late: single, then a fresh PRESS1 -> single.
    btn_in = 1'b1;
    wait_n(50);
    b = cyc;
    btn_in = 1'b0;
    expect_evt(K_SINGLE, b + 303);
    wait_n(301);
    btn_in = 1'b1;
    wait_n(50);
    d = cyc;
    btn_in = 1'b0;
    expect_evt(K_SINGLE, d + 303);
    wait_n(310);
    check_eq("busy_after_late", 32'(busy), 32'd0);

    // Enable dropped during WAIT2: no event, mode held, idle next cycle.
    btn_in = 1'b1;
    wait_n(50);
    btn_in = 1'b0;
    wait_n(100);
    check_eq("busy_in_wait2", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_n(1);
    check_eq("busy_disabled", 32'(busy), 32'd0);
    check_eq("mode_hold_dis", 32'(mode), 32'(mdl_mode));
    wait_n(400);
    // Press started while disabled is ignored after enable returns.
    btn_in = 1'b1;
    wait_n(10);
    enable = 1'b1;
    wait_n(50);
    check_eq("busy_press_pre_en", 32'(busy), 32'd0);
    btn_in = 1'b0;
    wait_n(400);
    check_eq("busy_release_pre_en", 32'(busy), 32'd0);

    // Reset mid-press: outputs return to reset values immediately.
    single_tap(40);
    btn_in = 1'b1;
    wait_n(100);
    check_eq("busy_press1", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_mode", 32'(mode), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_evts", 32'({single_evt, double_evt, long_evt}), 32'd0);
    mdl_mode = 0;
    btn_in = 1'b0;
    wait_n(3);
    rstn = 1'b1;
    wait_n(5);

`ifdef TAP_GESTURE_REPEAT_EN
    // Auto-repeat: long then four repeats, mode 0,1,2,3,0.
    a = cyc;
    btn_in = 1'b1;
    expect_evt(K_LONG, a + 1003);
    expect_evt(K_SINGLE, a + 1253);
    expect_evt(K_SINGLE, a + 1503);
    expect_evt(K_SINGLE, a + 1753);
    expect_evt(K_SINGLE, a + 2003);
    wait_n(2010);
    btn_in = 1'b0;
    wait_n(10);
    check_eq("rpt_final_mode", 32'(mode), 32'd0);
`endif

    wait_n(20);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
